// File: rtl/dct_2d_sequencer.sv
// dct_2d_sequencer: drives a shared 8-lane 1D DCT datapath through a row pass,
// an on-chip transpose and a column pass, then streams the 8 column results out.
module dct_2d_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_LAT   = 4,
  parameter int ROW_SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH*8-1:0]   in_row,
  output logic [DATA_WIDTH*8-1:0]   dct_data_in,
  input  logic [DATA_WIDTH*8-1:0]   dct_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH*8-1:0]   out_vec,
  output logic                      out_last,
  output logic                      busy
);

  localparam int VW = DATA_WIDTH * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROW_DRAIN, S_COL_ISSUE, S_COL_DRAIN, S_OUTPUT
  } state_t;

  state_t                       r_state;
  logic                         r_in_ready;
  logic [2:0]                   r_row_cnt;
  logic [2:0]                   r_col;
  logic [2:0]                   r_k;
  logic [VW-1:0]                r_data_in;
  logic [VW-1:0]                r_out_vec;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic [PIPE_LAT:0]            r_tag_vld;
  logic [2:0]                   r_tag_idx [PIPE_LAT+1];
  logic signed [DATA_WIDTH-1:0] r_buf [8][8];
  logic [VW-1:0]                r_obuf [8];

  logic                         w_in_hs;
  logic                         w_tag_out;
  logic [2:0]                   w_tag_idx;
  logic                         w_row_cap;
  logic                         w_col_cap;
  logic                         w_row7;
  logic                         w_push;
  logic [2:0]                   w_push_idx;
  logic signed [DATA_WIDTH-1:0] w_row_sh [8];
  logic [VW-1:0]                w_col_vec;

  // in_ready is forced low while reset is held so no row is taken during reset
  assign in_ready    = r_in_ready & ~reset;
  assign dct_data_in = r_data_in;
  assign out_valid   = r_out_valid;
  assign out_vec     = r_out_vec;
  assign out_last    = r_out_last;
  assign busy        = (r_state != S_IDLE);

  assign w_in_hs   = in_valid & in_ready;
  assign w_tag_out = r_tag_vld[PIPE_LAT];
  assign w_tag_idx = r_tag_idx[PIPE_LAT];
  assign w_row_cap = w_tag_out && (r_state == S_LOAD || r_state == S_ROW_DRAIN);
  assign w_col_cap = w_tag_out && (r_state == S_COL_ISSUE || r_state == S_COL_DRAIN);
  assign w_row7    = w_row_cap && (w_tag_idx == 3'd7);

  // Row results scaled by ROW_SHIFT (arithmetic, floors toward -inf);
  // column vector selection, with row 7 bypassed from the datapath so that
  // column 0 issues on the same edge that captures the last row.
  always_comb begin
    w_col_vec = '0;
    for (int u = 0; u < 8; u++)
      w_row_sh[u] = $signed(dct_out[u*DATA_WIDTH +: DATA_WIDTH]) >>> ROW_SHIFT;
    for (int r = 0; r < 8; r++) begin
      if (w_row7)
        w_col_vec[r*DATA_WIDTH +: DATA_WIDTH] = (r == 7) ? w_row_sh[0] : r_buf[r][0];
      else
        w_col_vec[r*DATA_WIDTH +: DATA_WIDTH] = r_buf[r][r_col];
    end
  end

  // Issue tag source: input rows, first column (at last row capture), later columns
  always_comb begin
    w_push     = 1'b0;
    w_push_idx = 3'd0;
    if (w_in_hs) begin
      w_push     = 1'b1;
      w_push_idx = r_row_cnt;
    end else if (w_row7) begin
      w_push     = 1'b1;
      w_push_idx = 3'd0;
    end else if (r_state == S_COL_ISSUE) begin
      w_push     = 1'b1;
      w_push_idx = r_col;
    end
  end

  // Tag shift register tracks which row/column emerges from the datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) r_tag_idx[i] <= 3'd0;
    end else begin
      r_tag_vld    <= {r_tag_vld[PIPE_LAT-1:0], w_push};
      r_tag_idx[0] <= w_push_idx;
      for (int i = 1; i <= PIPE_LAT; i++) r_tag_idx[i] <= r_tag_idx[i-1];
    end
  end

  // Transpose buffer (row results) and output buffer (column results)
  always_ff @(posedge clk) begin
    if (w_row_cap)
      for (int u = 0; u < 8; u++) r_buf[w_tag_idx][u] <= w_row_sh[u];
    if (w_col_cap)
      r_obuf[w_tag_idx] <= dct_out;
  end

  // Block sequencing FSM with registered handshake and output signals
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_row_cnt   <= 3'd0;
      r_col       <= 3'd0;
      r_k         <= 3'd0;
      r_data_in   <= '0;
      r_out_vec   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_hs) begin
            r_data_in <= in_row;
            r_row_cnt <= 3'd1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_in_hs) begin
            r_data_in <= in_row;
            r_row_cnt <= r_row_cnt + 3'd1;
            if (r_row_cnt == 3'd7) begin
              r_in_ready <= 1'b0;
              r_state    <= S_ROW_DRAIN;
            end
          end
        end
        S_ROW_DRAIN: begin
          if (w_row7) begin
            r_data_in <= w_col_vec;
            r_col     <= 3'd1;
            r_state   <= S_COL_ISSUE;
          end
        end
        S_COL_ISSUE: begin
          r_data_in <= w_col_vec;
          r_col     <= r_col + 3'd1;
          if (r_col == 3'd7) r_state <= S_COL_DRAIN;
        end
        S_COL_DRAIN: begin
          if (w_col_cap && w_tag_idx == 3'd7) begin
            r_out_vec   <= r_obuf[0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_k         <= 3'd0;
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (r_k == 3'd7) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_k         <= 3'd0;
              r_state     <= S_IDLE;
            end else begin
              r_out_vec  <= r_obuf[r_k + 3'd1];
              r_out_last <= (r_k == 3'd6);
              r_k        <= r_k + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dct_2d_sequencer.md
# dct_2d_sequencer

Sequences a shared `dct_1d_8x1` datapath through a full 8x8 two-dimensional DCT. The pass order is row pass, then transpose, then column pass. Rows arrive over a valid/ready stream and are issued to the 1D datapath as they arrive. Row results are collected in an internal 64-word transpose buffer, and column results are re-streamed to the output with valid/ready. The block sits between the block-splitter/level-shift stage and quantisation. Externally it owns the 1D DCT's `data_in` and `dct_out`; the coefficient matrix is wired directly from the coefficient ROM.

## Interface
- `DATA_WIDTH`, 32: width of one signed lane.
- `PIPE_LAT`, 4: cycles from `dct_data_in` being driven to the matching `dct_out` being valid (fixed latency of the 1D datapath). Legal range is 1..15.
- `ROW_SHIFT`, 0: arithmetic right shift applied to row-pass results before they are stored.
- `clk` in 1: rising-edge clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `in_valid` in 1: input row valid.
- `in_ready` out 1: block accepts an input row.
- `in_row` in DATA_WIDTH*8: one input row; lane i is `[i*DATA_WIDTH +: DATA_WIDTH]` = X[r][i].
- `dct_data_in` out DATA_WIDTH*8: registered vector driven to the 1D datapath.
- `dct_out` in DATA_WIDTH*8: result vector from the 1D datapath.
- `out_valid` out 1: output vector valid.
- `out_ready` in 1: downstream accepts the output vector.
- `out_vec` out DATA_WIDTH*8: output vector k; lane v = Y[v][k].
- `out_last` out 1: high with the 8th output vector (k = 7).
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, ROW_DRAIN, COL_ISSUE, COL_DRAIN, OUTPUT.
- **IDLE:** `in_ready`=1. The first handshake stores the row index (0) and moves to LOAD.
- **LOAD:** `in_ready`=1 until 8 rows have been accepted.
  - Each handshake on row r registers `in_row` into `dct_data_in`.
  - Each handshake pushes a 1 into a PIPE_LAT-deep issue-tag shift register, together with index r.
  - After the 8th handshake, move to ROW_DRAIN and deassert `in_ready`.
- **ROW_DRAIN:** when a tag emerges, `dct_out` is written to buffer row r: buf[r][u] = `dct_out` lane u >>> ROW_SHIFT.
  - The shift is sign-extending and truncates toward minus infinity.
  - The capture of row 7 moves the state to COL_ISSUE. Captures also occur during LOAD.
- **COL_ISSUE:** for c = 0..7 on consecutive cycles, `dct_data_in` lane r = buf[r][c], and a tag with index c is pushed. After c = 7, move to COL_DRAIN.
- **COL_DRAIN:** a tag with index c writes `dct_out` unshifted into output buffer entry c. The capture of c = 7 moves the state to OUTPUT.
- **OUTPUT:** `out_vec` = entry k, starting at k = 0. `out_valid`=1.
  - On an `out_valid` && `out_ready` handshake, k increments.
  - The handshake with k = 7 (`out_last`=1) returns the state to IDLE.
- There is no block overlap: `in_ready`=0 from the 8th accepted row until return to IDLE.
- Arithmetic: the block does no add or multiply. The only arithmetic is the ROW_SHIFT applied to row results. Lane widths are preserved with no saturation.
- `dct_data_in` holds its last value when no issue occurs. The datapath output is ignored when no tag emerges.
- A `reset` held in any state, mid-block included, takes effect at the next edge:
  - state returns to IDLE;
  - counters, tags, `out_valid`, `busy`, and `out_last` are cleared;
  - the partial block is discarded.

## Timing
- Reset values:
  - `in_ready`=0 during reset and 1 on the first cycle after reset;
  - `out_valid`=0, `out_last`=0, `busy`=0;
  - `dct_data_in`=0, `out_vec`=0.
- Row r is accepted at cycle t. `dct_data_in` carries it during cycle t+1, and the result is captured at the end of cycle t+1+PIPE_LAT.
- With `in_valid` held high and the first handshake at cycle 0:
  - rows are accepted at cycles 0..7;
  - column c is driven at cycle 9+PIPE_LAT+c;
  - `out_valid` first rises at cycle 17+2·PIPE_LAT (25 with the default).
- Once `out_valid` is asserted, `out_vec` and `out_last` are stable until the handshake.
- `out_ready` stalls only the OUTPUT state. The pipeline never stalls.
- Earliest next input handshake: the cycle after the k = 7 output handshake.
- A gap in `in_valid` during LOAD delays only the affected issues; the tag order preserves row indices.

## Test plan
- **Identity stub** (1D model = input delayed by PIPE_LAT), ROW_SHIFT=0, X[r][c] = 8r+c: the 8 outputs are the transpose, with vector k lane v = 8v+k, `out_last` on k = 7, and first `out_valid` at cycle 25.
- **Sign and shift:** identity stub, ROW_SHIFT=2, all inputs −5: every output lane = −2 (−5 >>> 2).
- **Backpressure:** `out_ready` toggles 1,0,0,1,… during OUTPUT. Vectors hold while stalled, none is dropped or duplicated, and `in_ready` stays 0 until the 8th handshake.
- **Input gaps:** `in_valid` low for 3 cycles between rows 3 and 4. Results match the first scenario, delayed 3 cycles.
- **Reset mid-operation:** assert `reset` for 1 cycle during COL_ISSUE (c = 3). Next cycle: `busy`=0, `in_ready`=1, `out_valid`=0. A fresh block then produces a correct transpose with no stale tags.
- **Back-to-back blocks:** two blocks with different values, and `out_ready` tied high. The second block's first row is accepted the cycle after the first block's `out_last`, and both outputs are correct.
